// File: rtl/count_check_if.sv
`default_nettype none
// ============================================================================
// Module      : count_check_if
// Description : Bundle between the counter side and the count_check
//               sequence checker. The counter side drives enable, count and
//               clear. The checker returns lock, error and event statistics.
//               The optional last_bad signal exists only when
//               COUNT_CHECK_LAST_BAD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface count_check_if #(
  parameter int ERRW = 8
);
  logic            enable;
  logic [15:0]     count;
  logic            clear;
  logic            locked;
  logic            error;
  logic [ERRW-1:0] err_count;
  logic [15:0]     wraps;
`ifdef COUNT_CHECK_LAST_BAD_EN
  logic [15:0]     last_bad;
`endif

  // Counter / bench side
  modport master (
    output enable, count, clear,
    input  locked, error, err_count, wraps
`ifdef COUNT_CHECK_LAST_BAD_EN
    , input last_bad
`endif
  );

  // Checker side
  modport slave (
    input  enable, count, clear,
    output locked, error, err_count, wraps
`ifdef COUNT_CHECK_LAST_BAD_EN
    , output last_bad
`endif
  );
endinterface
`default_nettype wire

// File: rtl/count_check.sv
`default_nettype none
// ============================================================================
// Module      : count_check
// Description : Sequence checker for a modulo-N enable-driven counter.
//               Each clock it predicts the next count from the previous
//               sample and enable. It flags mismatches with a sticky error
//               and a saturating error counter, counts correct N-1 -> 0
//               wraps, and reports lock while tracking cleanly.
//               Optional feature macro: COUNT_CHECK_LAST_BAD_EN. When it is
//               defined, last_bad records the count of the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module count_check #(
  parameter int N    = 8,
  parameter int ERRW = 8
) (
  input  logic          clock,
  input  logic          reset,   // asynchronous, active-low
  count_check_if.slave  bus
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [15:0]     MODULUS  = 16'(N);
  localparam logic [15:0]     LAST_VAL = 16'(N - 1);
  localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};

  state_t          state_q, state_d;
  logic [15:0]     prev_q;
  logic            en_d_q;
  logic            error_q;
  logic [ERRW-1:0] err_count_q;
  logic [15:0]     wraps_q;

  logic [15:0]     exp_val;
  logic            mismatch;
  logic            checking;
  logic            wrap_hit;

  // Prediction with an explicit wrap instead of a modulo operator.
  // An out-of-range count is always a mismatch, even if it equals the
  // prediction (possible after a resync onto a bad value).
  always_comb begin
    exp_val = prev_q;
    if (en_d_q) begin
      exp_val = (prev_q == LAST_VAL) ? 16'd0 : prev_q + 16'd1;
    end
    mismatch = (bus.count != exp_val) || (bus.count >= MODULUS);
    checking = (state_q == TRACK) || (state_q == ERROR);
    wrap_hit = checking && en_d_q && (prev_q == LAST_VAL) &&
               (bus.count == 16'd0) && !mismatch;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // Next-state logic. ERROR is left only via clear or reset.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = SYNC;
    end else begin
      case (state_q)
        SYNC:    state_d = TRACK;
        TRACK:   state_d = mismatch ? ERROR : TRACK;
        ERROR:   state_d = ERROR;
        default: state_d = SYNC;
      endcase
    end
  end

  // Sample history, sticky error, saturating error count, wrap counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q      <= 16'd0;
      en_d_q      <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      wraps_q     <= 16'd0;
    end else if (bus.clear) begin
      prev_q      <= 16'd0;
      en_d_q      <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      wraps_q     <= 16'd0;
    end else begin
      prev_q <= bus.count;
      en_d_q <= bus.enable;
      if (checking && mismatch) begin
        error_q <= 1'b1;
        if (err_count_q != ERR_MAX) err_count_q <= err_count_q + 1'b1;
      end
      if (wrap_hit) wraps_q <= wraps_q + 16'd1;
    end
  end

`ifdef COUNT_CHECK_LAST_BAD_EN
  logic [15:0] last_bad_q;

  // Capture only the first offending count (TRACK -> ERROR).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                              last_bad_q <= 16'd0;
    else if (bus.clear)                      last_bad_q <= 16'd0;
    else if (state_q == TRACK && mismatch)   last_bad_q <= bus.count;
  end

  assign bus.last_bad = last_bad_q;
`endif

  assign bus.locked    = (state_q == TRACK);
  assign bus.error     = error_q;
  assign bus.err_count = err_count_q;
  assign bus.wraps     = wraps_q;

endmodule
`default_nettype wire

// File: tb/tb_count_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_check
// Description : Directed self-checking bench for count_check (N=8, ERRW=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_check;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  count_check_if #(.ERRW(8)) bus ();
  count_check #(.N(8), .ERRW(8)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Present one count/enable pair and let one edge sample it.
  task automatic step(input logic [15:0] c, input logic e);
    bus.count  = c;
    bus.enable = e;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.clear = 1'b0;
    reset     = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.clear = 1'b0; bus.enable = 1'b0; bus.count = 16'd0;
    reset = 1'b0;
    #12;
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0d want=0", bus.locked); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0d want=0", bus.error); end
    total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", bus.err_count); end
    total++; if (bus.wraps !== 16'd0) begin bad++; $display("FAIL reset_wraps got=%0d want=0", bus.wraps); end
`ifdef COUNT_CHECK_LAST_BAD_EN
    total++; if (bus.last_bad !== 16'd0) begin bad++; $display("FAIL reset_last_bad got=%0d want=0", bus.last_bad); end
`endif
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  // Test 1: 20 counts with enable=1 -> two wraps.
  task automatic test_basic();
    step(16'd0, 1'b1);
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL basic_lock_first got=%0d want=1", bus.locked); end
    for (int i = 1; i < 20; i++) step(16'(i % 8), 1'b1);
    total++; if (bus.wraps !== 16'd2) begin bad++; $display("FAIL basic_wraps got=%0d want=2", bus.wraps); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL basic_error got=%0d want=0", bus.error); end
    total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL basic_errcnt got=%0d want=0", bus.err_count); end
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL basic_locked got=%0d want=1", bus.locked); end
  endtask

  // Test 2: enable pattern 1,0,0,1,1,0 with a correctly following counter.
  // Continues from test 1 (last count 3, last enable 1).
  task automatic test_enable_pattern();
    logic [5:0]  pat = 6'b011001;  // bit i = enable in cycle i%6
    logic [15:0] c = 16'd3;
    logic        en_prev = 1'b1;
    logic        en;
    int          wexp = 2;
    int          unlocked = 0;
    for (int i = 0; i < 50; i++) begin
      if (en_prev) begin
        if (c == 16'd7) begin c = 16'd0; wexp++; end
        else c = c + 16'd1;
      end
      en = pat[i % 6];
      step(c, en);
      if (bus.locked !== 1'b1) unlocked++;
      en_prev = en;
    end
    total++; if (unlocked !== 0) begin bad++; $display("FAIL pattern_locked unlocked_cycles=%0d want=0", unlocked); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL pattern_error got=%0d want=0", bus.error); end
    total++; if (bus.wraps !== 16'(wexp)) begin bad++; $display("FAIL pattern_wraps got=%0d want=%0d", bus.wraps, wexp); end
  endtask

  // Test 3: count 5 where 3 is expected, then continue correctly from 5.
  task automatic test_single_error();
    do_reset();
    step(16'd0, 1'b1); step(16'd1, 1'b1); step(16'd2, 1'b1);
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL single_pre_error got=%0d want=0", bus.error); end
    step(16'd5, 1'b1);
    total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL single_error got=%0d want=1", bus.error); end
    total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL single_errcnt got=%0d want=1", bus.err_count); end
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL single_locked got=%0d want=0", bus.locked); end
    step(16'd6, 1'b1); step(16'd7, 1'b1); step(16'd0, 1'b1); step(16'd1, 1'b1);
    total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL single_no_more got=%0d want=1", bus.err_count); end
    total++; if (bus.wraps !== 16'd1) begin bad++; $display("FAIL single_wrap_in_error got=%0d want=1", bus.wraps); end
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL single_stay_error got=%0d want=0", bus.locked); end
`ifdef COUNT_CHECK_LAST_BAD_EN
    total++; if (bus.last_bad !== 16'd5) begin bad++; $display("FAIL single_last_bad got=%0d want=5", bus.last_bad); end
`endif
  endtask

  // Test 4: out-of-range count, and a 0 after 7 with enable low.
  task automatic test_boundaries();
    do_reset();
    step(16'd5, 1'b1); step(16'd6, 1'b1);
    step(16'd9, 1'b1);
    total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL range_errcnt got=%0d want=1", bus.err_count); end
    step(16'd9, 1'b0);   // expected 10 -> mismatch
    step(16'd9, 1'b0);   // equals prediction 9 but out of range -> mismatch
    total++; if (bus.err_count !== 8'd3) begin bad++; $display("FAIL range_hold_errcnt got=%0d want=3", bus.err_count); end
`ifdef COUNT_CHECK_LAST_BAD_EN
    total++; if (bus.last_bad !== 16'd9) begin bad++; $display("FAIL range_last_bad got=%0d want=9", bus.last_bad); end
`endif
    do_reset();
    step(16'd6, 1'b1); step(16'd7, 1'b0);
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL nowrap_pre_error got=%0d want=0", bus.error); end
    step(16'd0, 1'b1);
    total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL nowrap_errcnt got=%0d want=1", bus.err_count); end
    total++; if (bus.wraps !== 16'd0) begin bad++; $display("FAIL nowrap_wraps got=%0d want=0", bus.wraps); end
  endtask

  // Test 5: 300 mismatches saturate the error counter at 255.
  task automatic test_saturate();
    do_reset();
    step(16'd0, 1'b1);
    for (int i = 0; i < 254; i++) step(16'd3, 1'b1);
    total++; if (bus.err_count !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d want=254", bus.err_count); end
    step(16'd3, 1'b1);
    total++; if (bus.err_count !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", bus.err_count); end
    for (int i = 0; i < 45; i++) step(16'd3, 1'b1);
    total++; if (bus.err_count !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", bus.err_count); end
    total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL sat_error got=%0d want=1", bus.error); end
  endtask

  // Test 6: synchronous clear pulse / hold, then asynchronous reset mid-cycle.
  task automatic test_clear_reset();
    do_reset();
    step(16'd0, 1'b1);
    for (int i = 1; i <= 8; i++) step(16'(i % 8), 1'b1);
    step(16'd5, 1'b1);
    total++; if (bus.wraps !== 16'd1 || bus.error !== 1'b1) begin bad++; $display("FAIL clr_setup wraps=%0d error=%0d want 1 1", bus.wraps, bus.error); end
    bus.clear = 1'b1;
    step(16'd6, 1'b1);
    total++; if ({bus.locked, bus.error, bus.err_count, bus.wraps} !== 26'd0) begin bad++; $display("FAIL clr_outputs locked=%0d error=%0d errcnt=%0d wraps=%0d want all 0", bus.locked, bus.error, bus.err_count, bus.wraps); end
`ifdef COUNT_CHECK_LAST_BAD_EN
    total++; if (bus.last_bad !== 16'd0) begin bad++; $display("FAIL clr_last_bad got=%0d want=0", bus.last_bad); end
`endif
    step(16'd7, 1'b1); step(16'd0, 1'b1);
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL clr_hold_locked got=%0d want=0", bus.locked); end
    bus.clear = 1'b0;
    step(16'd2, 1'b1);
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL clr_relock got=%0d want=1", bus.locked); end
    step(16'd3, 1'b1); step(16'd4, 1'b1); step(16'd9, 1'b1);
    total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL rst_setup got=%0d want=1", bus.error); end
    #2;
    reset = 1'b0;
    #1;
    total++; if ({bus.locked, bus.error, bus.err_count, bus.wraps} !== 26'd0) begin bad++; $display("FAIL rst_async locked=%0d error=%0d errcnt=%0d want all 0", bus.locked, bus.error, bus.err_count); end
    @(posedge clock); #1;
    reset = 1'b1;
    step(16'd0, 1'b1);
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL rst_relock got=%0d want=1", bus.locked); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable_pattern();
    test_single_error();
    test_boundaries();
    test_saturate();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
